// File: rtl/lc_dpll_pkg.sv
// Shared types and helpers for the LC-tank DPLL acquisition core.
package lc_dpll_pkg;

  typedef enum logic [1:0] {
    SWEEP = 2'd0,
    ACQ   = 2'd1,
    LOCK  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  // Width of the consecutive balanced/unbalanced window counters (saturating).
  localparam int CNT_W = 8;

  function automatic logic [31:0] freq_min_of(input int freq_w, input int range_w);
    return 32'd1 << (freq_w - range_w);
  endfunction

  function automatic logic [31:0] sat_add(input logic [31:0] val, input logic up,
                                          input logic [31:0] lo, input logic [31:0] hi);
    if (up) return (val >= hi) ? hi : val + 32'd1;
    return (val <= lo) ? lo : val - 32'd1;
  endfunction

endpackage

// File: rtl/lock_det.sv
// Windowed lock detector: counts error-bit cycles per window and flags balance at window end.
module lock_det #(
  parameter int WIN_W    = 8,
  parameter int LOCK_TOL = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic e,
  output logic win_end,
  output logic balanced
);

  localparam logic [WIN_W:0]   HALF    = (WIN_W+1)'(1) << (WIN_W - 1);
  localparam logic [WIN_W:0]   TOL     = (WIN_W+1)'(LOCK_TOL);
  localparam logic [WIN_W-1:0] LAST_M1 = ~WIN_W'(1);

  logic [WIN_W-1:0] win_cnt;
  logic [WIN_W:0]   err_cnt;
  logic [WIN_W:0]   err_total;
  logic [WIN_W:0]   dev;

  // The window-end cycle's own error bit is part of that window's count.
  assign err_total = err_cnt + (WIN_W+1)'(e);
  assign dev       = (err_total >= HALF) ? err_total - HALF : HALF - err_total;
  assign balanced  = (dev <= TOL);

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      win_cnt <= '0;
      err_cnt <= '0;
      win_end <= 1'b0;
    end else begin
      win_cnt <= win_cnt + WIN_W'(1);
      err_cnt <= win_end ? '0 : err_total;
      win_end <= (win_cnt == LAST_M1);
    end
  end

endmodule

// File: rtl/lc_dpll_acq.sv
// LC-tank DPLL core: input resync, acquisition FSM, saturating integrator and NCO.
module lc_dpll_acq
  import lc_dpll_pkg::*;
#(
  parameter int FREQ_W     = 25,
  parameter int NCO_W      = 30,
  parameter int RANGE_W    = 4,
  parameter int SYNC_W     = 2,
  parameter int WIN_W      = 8,
  parameter int LOCK_TOL   = 16,
  parameter int LOCK_WINS  = 4,
  parameter int LOSS_WINS  = 2,
  parameter int SWEEP_STEP = 1024
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              restart_i,
  input  logic              hold_i,
  input  logic              zero_i,
  input  logic              quad_i,
  output logic              sq_o,
  output logic [FREQ_W-1:0] freq_o,
  output logic              lock_o,
  output logic [1:0]        state_o,
  output logic              win_o
);

  localparam logic [FREQ_W-1:0] FREQ_MIN = FREQ_W'(freq_min_of(FREQ_W, RANGE_W));
  localparam logic [FREQ_W-1:0] FREQ_MAX = '1;
  localparam logic [FREQ_W:0]   STEP     = (FREQ_W+1)'(SWEEP_STEP);

  logic [SYNC_W-1:0] zero_sync, quad_sync;
  logic              e;
  logic              win_end, balanced;
  state_t            state, state_nxt;
  logic [FREQ_W-1:0] freq, freq_nxt;
  logic [FREQ_W:0]   swept;
  logic              lock, lock_nxt;
  logic [CNT_W-1:0]  bal_cnt, bal_nxt, loss_cnt, loss_nxt;
  logic [NCO_W-1:0]  acc;
  logic              sq;

  // Resync is deliberately left running through restart; only reset clears it.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      zero_sync <= '0;
      quad_sync <= '0;
    end else begin
      zero_sync <= (zero_sync << 1) | SYNC_W'(zero_i);
      quad_sync <= (quad_sync << 1) | SYNC_W'(quad_i);
    end
  end

  assign e = zero_sync[SYNC_W-1] ^ quad_sync[SYNC_W-1];

  lock_det #(.WIN_W(WIN_W), .LOCK_TOL(LOCK_TOL)) u_lock_det (
    .clk      (clk_i),
    .rst_n    (rst_n_i),
    .clr      (restart_i | hold_i),
    .e        (e),
    .win_end  (win_end),
    .balanced (balanced)
  );

  always_comb begin
    state_nxt = state;
    freq_nxt  = freq;
    lock_nxt  = lock;
    bal_nxt   = bal_cnt;
    loss_nxt  = loss_cnt;
    swept     = {1'b0, freq} + STEP;
    if (restart_i) begin
      state_nxt = SWEEP;
      freq_nxt  = FREQ_MIN;
      lock_nxt  = 1'b0;
      bal_nxt   = '0;
      loss_nxt  = '0;
    end else if (hold_i) begin
      state_nxt = HOLD;
    end else if (state == HOLD) begin
      state_nxt = ACQ;
      lock_nxt  = 1'b0;
      bal_nxt   = '0;
      loss_nxt  = '0;
    end else begin
      if (state != SWEEP)
        freq_nxt = FREQ_W'(sat_add(32'(freq), e, 32'(FREQ_MIN), 32'(FREQ_MAX)));
      if (win_end) begin
        if (balanced) begin
          bal_nxt  = (&bal_cnt) ? bal_cnt : bal_cnt + CNT_W'(1);
          loss_nxt = '0;
        end else begin
          loss_nxt = (&loss_cnt) ? loss_cnt : loss_cnt + CNT_W'(1);
          bal_nxt  = '0;
        end
        case (state)
          SWEEP: begin
            if (balanced) state_nxt = ACQ;
            else freq_nxt = (swept > {1'b0, FREQ_MAX}) ? FREQ_MIN : swept[FREQ_W-1:0];
          end
          ACQ: begin
            if (balanced && bal_nxt >= CNT_W'(LOCK_WINS)) begin
              state_nxt = LOCK;
              lock_nxt  = 1'b1;
            end else if (!balanced && loss_nxt >= CNT_W'(LOSS_WINS)) begin
              state_nxt = SWEEP;
            end
          end
          LOCK: begin
            if (!balanced && loss_nxt >= CNT_W'(LOSS_WINS)) begin
              state_nxt = SWEEP;
              lock_nxt  = 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state    <= SWEEP;
      freq     <= FREQ_MIN;
      lock     <= 1'b0;
      bal_cnt  <= '0;
      loss_cnt <= '0;
    end else begin
      state    <= state_nxt;
      freq     <= freq_nxt;
      lock     <= lock_nxt;
      bal_cnt  <= bal_nxt;
      loss_cnt <= loss_nxt;
    end
  end

  // Accumulator keeps its phase across restart so the tank drive stays continuous.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      acc <= '0;
      sq  <= 1'b0;
    end else begin
      acc <= acc + NCO_W'(freq);
      sq  <= acc[NCO_W-1];
    end
  end

  assign sq_o    = sq;
  assign freq_o  = freq;
  assign lock_o  = lock;
  assign state_o = state;
  assign win_o   = win_end;

endmodule

// File: tb/tb_lc_dpll_acq.sv
// Directed scoreboard bench for lc_dpll_acq: reset, sweep/wrap, acquire, lock, loss, hold/restart.
module tb_lc_dpll_acq;

  localparam logic [31:0] FMIN = 32'h0020_0000;
  localparam logic [31:0] F    = FMIN + 32'd3072;
  localparam logic [31:0] G    = F - 32'd510;

  typedef struct {
    string       tag;
    logic [31:0] freq;
    logic [31:0] state;
    logic [31:0] lock;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n, restart, hold, zero, quad;
  logic        sq, lock, win;
  logic [24:0] freq;
  logic [1:0]  state;
  logic        zero2 = 1'b1, quad2 = 1'b0, restart2 = 1'b0, hold2 = 1'b0;
  logic        sq2, lock2, win2;
  logic [11:0] freq2;
  logic [1:0]  state2;

  int   checks = 0;
  int   failures = 0;
  int   win_seen = 0;
  int   cyc;
  bit   toggle_en = 1'b0;
  exp_t sb[$];

  always #5 clk = ~clk;

  lc_dpll_acq dut (
    .clk_i(clk), .rst_n_i(rst_n), .restart_i(restart), .hold_i(hold),
    .zero_i(zero), .quad_i(quad), .sq_o(sq), .freq_o(freq),
    .lock_o(lock), .state_o(state), .win_o(win)
  );

  lc_dpll_acq #(.FREQ_W(12), .RANGE_W(2)) dut_small (
    .clk_i(clk), .rst_n_i(rst_n), .restart_i(restart2), .hold_i(hold2),
    .zero_i(zero2), .quad_i(quad2), .sq_o(sq2), .freq_o(freq2),
    .lock_o(lock2), .state_o(state2), .win_o(win2)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push_exp(input string tag, input logic [31:0] f, input logic [31:0] s,
                          input logic [31:0] l);
    exp_t x;
    x.tag = tag; x.freq = f; x.state = s; x.lock = l;
    sb.push_back(x);
  endtask

  task automatic check_output();
    exp_t x;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("[TB] FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      x = sb.pop_front();
      check_val({x.tag, "_freq"}, 32'(freq), x.freq);
      check_val({x.tag, "_state"}, 32'(state), x.state);
      check_val({x.tag, "_lock"}, 32'(lock), x.lock);
    end
  endtask

  // Sample on the falling edge, then drive the next input value.
  task automatic apply_stimulus();
    @(negedge clk);
    if (win === 1'b1) win_seen++;
    if (toggle_en) quad = ~quad;
  endtask

  task automatic wait_win(input string tag);
    bit found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      apply_stimulus();
      found = (win === 1'b1);
    end
    if (!found) begin
      checks++;
      failures++;
      $error("[TB] FAIL %s_timeout observed=0 expected=1", tag);
    end
    apply_stimulus();
  endtask

  initial begin
    rst_n = 1'b0; restart = 1'b0; hold = 1'b0; zero = 1'b0; quad = 1'b0;
    repeat (3) begin
      @(negedge clk);
      zero = 1'($urandom);
      quad = 1'($urandom);
    end
    push_exp("reset", FMIN, 0, 0);
    check_output();
    check_val("reset_sq", 32'(sq), 0);
    check_val("reset_win", 32'(win), 0);
    check_val("reset_freq_small", 32'(freq2), 32'd1024);

    rst_n = 1'b1; zero = 1'b1; quad = 1'b0;
    push_exp("sweep_w1", FMIN + 32'd1024, 0, 0);
    cyc = 1;
    while (win !== 1'b1 && cyc < 400) begin
      apply_stimulus();
      cyc++;
    end
    check_val("first_win_cycle", cyc, 256);
    apply_stimulus();
    check_output();
    check_val("sweep_w1_small", 32'(freq2), 32'd2048);
    check_val("sq_before", 32'(sq), 0);
    apply_stimulus();
    check_val("sq_rise", 32'(sq), 1);

    push_exp("sweep_w2", FMIN + 32'd2048, 0, 0);
    wait_win("sweep_w2");
    check_output();
    check_val("sweep_w2_small", 32'(freq2), 32'd3072);
    push_exp("sweep_w3", F, 0, 0);
    wait_win("sweep_w3");
    check_output();
    check_val("wrap_small", 32'(freq2), 32'd1024);

    zero = 1'b0; quad = 1'b1; toggle_en = 1'b1;
    push_exp("acq_entry", F, 1, 0);
    wait_win("acq_entry");
    check_output();
    push_exp("acq_w2", F, 1, 0);
    wait_win("acq_w2");
    check_output();
    push_exp("acq_w3", F, 1, 0);
    wait_win("acq_w3");
    check_output();
    push_exp("lock", F, 2, 1);
    wait_win("lock");
    check_output();

    toggle_en = 1'b0; quad = 1'b0;
    repeat (8) apply_stimulus();
    check_val("loss_decrement", 32'(freq), F - 32'd6);
    push_exp("loss_w1", F - 32'd254, 2, 1);
    wait_win("loss_w1");
    check_output();
    push_exp("loss_w2", G, 0, 0);
    wait_win("loss_w2");
    check_output();

    quad = 1'b1; toggle_en = 1'b1;
    push_exp("relock_acq", G, 1, 0);
    wait_win("relock_acq");
    check_output();
    repeat (2) wait_win("relock_mid");
    push_exp("relock", G, 2, 1);
    wait_win("relock");
    check_output();

    hold = 1'b1;
    push_exp("hold_enter", G, 3, 1);
    apply_stimulus();
    check_output();
    win_seen = 0;
    repeat (300) apply_stimulus();
    check_val("hold_no_win", win_seen, 0);
    push_exp("hold_frozen", G, 3, 1);
    check_output();

    restart = 1'b1; toggle_en = 1'b0; quad = 1'b0; zero = 1'b0;
    push_exp("restart_over_hold", FMIN, 0, 0);
    apply_stimulus();
    restart = 1'b0;
    check_output();
    push_exp("rehold", FMIN, 3, 0);
    apply_stimulus();
    check_output();
    hold = 1'b0;
    push_exp("hold_exit", FMIN, 1, 0);
    apply_stimulus();
    check_output();
    repeat (8) apply_stimulus();
    push_exp("sat_floor", FMIN, 1, 0);
    check_output();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
